// File: rtl/clock_pkg.sv
// Shared time-of-day limits and field widths, reused by the display and alarm blocks.
package clock_pkg;

  localparam int HH_W = 5;
  localparam int MS_W = 6;

  localparam logic [HH_W-1:0] HH_MAX = 5'd23;
  localparam logic [MS_W-1:0] MM_MAX = 6'd59;
  localparam logic [MS_W-1:0] SS_MAX = 6'd59;

  typedef struct packed {
    logic [HH_W-1:0] hh;
    logic [MS_W-1:0] mm;
    logic [MS_W-1:0] ss;
  } hms_t;

  // True when every field of a requested time lies inside its legal range.
  function automatic logic fields_in_range(input logic [HH_W-1:0] h,
                                           input logic [MS_W-1:0] m,
                                           input logic [MS_W-1:0] s);
    return (h <= HH_MAX) && (m <= MM_MAX) && (s <= SS_MAX);
  endfunction

endpackage

// File: rtl/clk_timekeeper_tick_sync.sv
// Brings the divider's square wave into the clk domain and flags every toggle.
// The edge output is named d_edge because "edge" is a reserved word.
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_edge
);

  logic s1, s2, s3;

  // Two-flop synchroniser followed by a history flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Both rising and falling edges of the slow clock count as a tick.
  assign d_edge = s2 ^ s3;

endmodule

// File: rtl/clk_timekeeper.sv
// 24 h time-of-day counter driven by synchronised divider ticks, with run/pause
// control and a range-checked time-set handshake.
module clk_timekeeper
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int SUB_W         = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_in,
  input  logic            run,
  input  logic            set_valid,
  input  logic [HH_W-1:0] set_hh,
  input  logic [MS_W-1:0] set_mm,
  input  logic [MS_W-1:0] set_ss,
  output logic            set_ready,
  output logic            set_err,
  output logic [HH_W-1:0] hh,
  output logic [MS_W-1:0] mm,
  output logic [MS_W-1:0] ss,
  output logic            sec_pulse
);

  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

  logic             tick;
  logic [SUB_W-1:0] sub;
  logic             set_acc;
  logic             set_ok;
  logic             load;
  logic             cnt;
  logic             sec_adv;
  logic             ss_wrap;
  logic             mm_wrap;
  logic             hh_wrap;

  tick_sync u_tick_sync (
    .clk    (clk),
    .rst    (rst),
    .d_in   (tick_in),
    .d_edge (tick)
  );

  // A loaded set takes priority over a coincident tick; a rejected set does not.
  always_comb begin
    set_acc = set_valid & set_ready;
    set_ok  = fields_in_range(set_hh, set_mm, set_ss);
    load    = set_acc & set_ok;
    cnt     = tick & run & ~load;
    sec_adv = cnt & (sub == SUB_MAX);
    ss_wrap = (ss == SS_MAX);
    mm_wrap = (mm == MM_MAX);
    hh_wrap = (hh == HH_MAX);
  end

  // Sub-second tick counter; cleared by a successful set, frozen while paused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub <= '0;
    end else if (load) begin
      sub <= '0;
    end else if (cnt) begin
      sub <= (sub == SUB_MAX) ? '0 : sub + SUB_W'(1);
    end
  end

  // Cascaded seconds/minutes/hours; wraps are compared before incrementing so no
  // field ever shows an out-of-range value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hh <= '0;
      mm <= '0;
      ss <= '0;
    end else if (load) begin
      hh <= set_hh;
      mm <= set_mm;
      ss <= set_ss;
    end else if (sec_adv) begin
      ss <= ss_wrap ? '0 : ss + 6'd1;
      if (ss_wrap) begin
        mm <= mm_wrap ? '0 : mm + 6'd1;
        if (mm_wrap) begin
          hh <= hh_wrap ? '0 : hh + 5'd1;
        end
      end
    end
  end

  // Handshake and status pulses: ready drops for one cycle after any accepted set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_ready <= 1'b0;
      set_err   <= 1'b0;
      sec_pulse <= 1'b0;
    end else begin
      set_ready <= ~set_acc;
      set_err   <= set_acc & ~set_ok;
      sec_pulse <= sec_adv;
    end
  end

endmodule

// File: tb/tb_clk_timekeeper.sv
// Randomised scoreboard bench for clk_timekeeper, run with 4 ticks per second.
module tb_clk_timekeeper;

  localparam int TPS = 4;
  localparam int DAY = 86400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hh = '0;
  logic [5:0] set_mm = '0;
  logic [5:0] set_ss = '0;
  logic       set_ready;
  logic       set_err;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       sec_pulse;

  clk_timekeeper #(.TICKS_PER_SEC(TPS), .SUB_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .run       (run),
    .set_valid (set_valid),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
    .set_ready (set_ready),
    .set_err   (set_err),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .sec_pulse (sec_pulse)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int at;
    int secs;
  } ev_t;

  ev_t pulse_q[$];
  int  err_q[$];

  // Reference model: time of day as seconds since midnight plus a sub-second count.
  int secs_m = 0;
  int sub_m  = 0;
  bit run_m  = 1'b0;

  function automatic int tod();
    return int'(hh) * 3600 + int'(mm) * 60 + int'(ss);
  endfunction

  function automatic void model_tick(int at);
    if (!run_m) return;
    sub_m++;
    if (sub_m == TPS) begin
      sub_m  = 0;
      secs_m = (secs_m + 1) % DAY;
      pulse_q.push_back('{at: at, secs: secs_m});
    end
  endfunction

  function automatic bit fields_ok(int h, int m, int s);
    return (h <= 23) && (m <= 59) && (s <= 59);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected sec_pulse / set_err events as the DUT presents them.
  ev_t e;
  int  ea;
  always @(negedge clk) begin
    if (rst) begin
      if (sec_pulse) begin
        checks++;
        if (pulse_q.size() == 0) begin
          errors++;
          $display("FAIL sec_pulse: unexpected pulse at cycle %0d, time %0d, none required", cyc, tod());
        end else begin
          e = pulse_q.pop_front();
          if (e.at != cyc || e.secs != tod()) begin
            errors++;
            $display("FAIL sec_pulse: got cycle %0d time %0d, expected cycle %0d time %0d",
                     cyc, tod(), e.at, e.secs);
          end
        end
      end else if (pulse_q.size() > 0 && pulse_q[0].at <= cyc) begin
        checks++;
        errors++;
        e = pulse_q.pop_front();
        $display("FAIL sec_pulse: got none at cycle %0d, expected pulse with time %0d", cyc, e.secs);
      end
      if (set_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL set_err: unexpected pulse at cycle %0d, none required", cyc);
        end else begin
          ea = err_q.pop_front();
          if (ea != cyc) begin
            errors++;
            $display("FAIL set_err: got cycle %0d expected cycle %0d", cyc, ea);
          end
        end
      end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
        checks++;
        errors++;
        ea = err_q.pop_front();
        $display("FAIL set_err: got none at cycle %0d, expected at cycle %0d", cyc, ea);
      end
    end
  end

  task automatic settle();
    repeat (5) @(negedge clk);
  endtask

  task automatic check_time(string name);
    chk(name, tod(), secs_m);
  endtask

  // Called positioned on a negedge; toggles the divider output and waits gap cycles.
  task automatic toggle(int gap);
    tick_in = ~tick_in;
    model_tick(cyc + 3);
    repeat (gap) @(negedge clk);
  endtask

  task automatic toggles(int n);
    for (int i = 0; i < n; i++) toggle($urandom_range(1, 3));
    settle();
  endtask

  // Set request; with coincide=1 a tick toggle is launched so its synced edge
  // lands on the very cycle the set is accepted.
  task automatic do_set(int h, int m, int s, bit coincide);
    int guard = 0;
    int k;
    while (!set_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!set_ready) begin
      checks++;
      errors++;
      $display("FAIL set_ready_timeout: got 0 after %0d cycles, expected 1", guard);
      return;
    end
    if (coincide) begin
      tick_in = ~tick_in;
      @(negedge clk);
      @(negedge clk);
    end
    set_valid = 1'b1;
    set_hh    = 5'(h);
    set_mm    = 6'(m);
    set_ss    = 6'(s);
    k = cyc + 1;
    if (fields_ok(h, m, s)) begin
      secs_m = h * 3600 + m * 60 + s;
      sub_m  = 0;
    end else begin
      if (coincide) model_tick(k);
      err_q.push_back(k);
    end
    @(negedge clk);
    chk("set_ready_low", int'(set_ready), 0);
    set_hh = 5'd1;
    set_mm = 6'd2;
    set_ss = 6'd3;
    @(negedge clk);
    chk("set_ready_back", int'(set_ready), 1);
    set_valid = 1'b0;
    settle();
    check_time("time_after_set");
  endtask

  task automatic pause(int n);
    run   = 1'b0;
    run_m = 1'b0;
    toggles(n);
    check_time("time_paused");
    run   = 1'b1;
    run_m = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(set_ready), 0);
    chk("reset_time", tod(), 0);
    chk("reset_pulse", int'(sec_pulse), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", int'(set_ready), 1);
    run   = 1'b1;
    run_m = 1'b1;

    toggles(8);
    chk("eight_toggles_ss", int'(ss), 2);
    check_time("eight_toggles");

    do_set(23, 59, 59, 1'b0);
    toggles(TPS);
    check_time("midnight_wrap");

    do_set(24, 0, 0, 1'b0);
    do_set(12, 60, 0, 1'b0);

    toggles(TPS - 1);
    do_set(10, 0, 0, 1'b1);
    toggles(TPS);
    check_time("set_wins_then_count");

    toggles(2);
    pause(10);
    toggles(2);
    check_time("resume_from_sub");

    do_set(0, 0, 59, 1'b0);
    toggles(TPS - 1);
    do_set(0, 0, 60, 1'b1);
    check_time("rejected_set_keeps_tick");

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: toggles($urandom_range(1, 6));
        5: do_set($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), 1'b0);
        6: case ($urandom_range(0, 2))
             0: do_set($urandom_range(24, 31), $urandom_range(0, 59), $urandom_range(0, 59), 1'($urandom_range(0, 1)));
             1: do_set($urandom_range(0, 23), $urandom_range(60, 63), $urandom_range(0, 59), 1'($urandom_range(0, 1)));
             default: do_set($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(60, 63), 1'($urandom_range(0, 1)));
           endcase
        7: do_set($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), 1'b1);
        8: pause($urandom_range(1, 5));
        default: do_set(23, 59, $urandom_range(55, 59), 1'b0);
      endcase
    end

    do_set(12, 34, 56, 1'b0);
    toggle(1);
    toggle(1);
    #3;
    rst     = 1'b0;
    tick_in = 1'b0;
    #1;
    chk("midreset_time", tod(), 0);
    chk("midreset_ready", int'(set_ready), 0);
    chk("midreset_pulse", int'(sec_pulse), 0);
    secs_m = 0;
    sub_m  = 0;
    pulse_q.delete();
    err_q.delete();
    repeat (3) @(negedge clk);
    chk("held_reset_ready", int'(set_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", int'(set_ready), 1);
    toggles(TPS);
    check_time("count_after_midreset");

    settle();
    chk("pending_pulses", pulse_q.size(), 0);
    chk("pending_errs", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
